// File: rtl/spi_memory_bridge_if.sv
// Core-side load/store bus plus SPI pins of the SPI memory bridge.
// The bridge uses the slave modport; the core/system side uses master.
interface spi_memory_bridge_if;
    logic        memory_read;
    logic        memory_write;
    logic [2:0]  option;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        memory_response;
    logic        busy;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    modport master (
        output memory_read, memory_write, option, address, write_data, spi_miso,
        input  read_data, memory_response, busy, spi_cs_n, spi_sck, spi_mosi
    );

    modport slave (
        input  memory_read, memory_write, option, address, write_data, spi_miso,
        output read_data, memory_response, busy, spi_cs_n, spi_sck, spi_mosi
    );
endinterface

// File: rtl/spi_memory_bridge.sv
// Bridges single core loads/stores to an SPI serial memory (mode 0,
// opcode + 24-bit address + 1/2/4 data bytes, lowest address first).
module spi_memory_bridge #(
    parameter int unsigned CLK_DIV   = 1,
    parameter logic [7:0]  READ_CMD  = 8'h03,
    parameter logic [7:0]  WRITE_CMD = 8'h02
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_memory_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        XFER,
        STOP,
        RELEASE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      r_state;
    logic [2:0]  r_option;
    logic        r_is_write;
    logic [63:0] r_tx;
    logic [31:0] r_rx;
    logic [7:0]  r_div_cnt;
    logic [6:0]  r_bit_cnt;
    logic        r_cs_n;
    logic        r_sck;
    logic        r_mosi;
    logic        r_response;
    logic        r_busy;
    logic [31:0] r_read_data;

    logic        w_req;
    logic [31:0] w_data_in;
    logic [63:0] w_tx_in;
    logic [31:0] w_rx_word;
    logic [6:0]  w_last_bit;
    logic [31:0] w_rd_ext;
    logic        w_unused;

    assign w_req    = bus.memory_read | bus.memory_write;
    assign w_unused = ^bus.address[31:24];

    // Store bytes go out lowest address first; received bytes are the
    // same order, so both directions are a plain byte reversal.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign w_data_in[8*(3-gi) +: 8] = bus.memory_write ? bus.write_data[8*gi +: 8] : 8'h00;
            assign w_rx_word[8*gi +: 8]     = r_rx[8*(3-gi) +: 8];
        end
    endgenerate

    assign w_tx_in = {(bus.memory_write ? WRITE_CMD : READ_CMD), bus.address[23:0], w_data_in};

    always_comb begin
        w_last_bit = 7'd63;
        case (r_option[1:0])
            2'b00:   w_last_bit = 7'd39;
            2'b01:   w_last_bit = 7'd47;
            default: w_last_bit = 7'd63;
        endcase
    end

    // Byte/half results sit in the top of w_rx_word after reversal.
    always_comb begin
        w_rd_ext = w_rx_word;
        case (r_option)
            3'b000:  w_rd_ext = {{24{w_rx_word[31]}}, w_rx_word[31:24]};
            3'b001:  w_rd_ext = {{16{w_rx_word[31]}}, w_rx_word[31:16]};
            3'b100:  w_rd_ext = {24'h000000, w_rx_word[31:24]};
            3'b101:  w_rd_ext = {16'h0000, w_rx_word[31:16]};
            default: w_rd_ext = w_rx_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_option    <= 3'b000;
            r_is_write  <= 1'b0;
            r_tx        <= 64'h0;
            r_rx        <= 32'h0;
            r_div_cnt   <= 8'h00;
            r_bit_cnt   <= 7'd0;
            r_cs_n      <= 1'b1;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_response  <= 1'b0;
            r_busy      <= 1'b0;
            r_read_data <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_option   <= bus.option;
                        r_is_write <= bus.memory_write;
                        r_tx       <= w_tx_in;
                        r_mosi     <= w_tx_in[63];
                        r_cs_n     <= 1'b0;
                        r_sck      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    r_div_cnt <= 8'h00;
                    r_bit_cnt <= 7'd0;
                    r_state   <= XFER;
                end
                XFER: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= 8'h00;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                            r_rx  <= {r_rx[30:0], bus.spi_miso};
                        end else begin
                            // Falling edge: next MOSI bit, or end of frame.
                            r_sck <= 1'b0;
                            if (r_bit_cnt == w_last_bit) begin
                                r_cs_n  <= 1'b1;
                                r_mosi  <= 1'b0;
                                r_state <= STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 7'd1;
                                r_tx      <= {r_tx[62:0], 1'b0};
                                r_mosi    <= r_tx[62];
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                STOP: begin
                    r_response <= 1'b1;
                    if (!r_is_write) begin
                        r_read_data <= w_rd_ext;
                    end
                    r_state <= RELEASE;
                end
                RELEASE: begin
                    r_response <= 1'b0;
                    r_busy     <= 1'b0;
                    if (!w_req) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.read_data       = r_read_data;
    assign bus.memory_response = r_response;
    assign bus.busy            = r_busy;
    assign bus.spi_cs_n        = r_cs_n;
    assign bus.spi_sck         = r_sck;
    assign bus.spi_mosi        = r_mosi;

endmodule

// File: tb/tb_spi_memory_bridge.sv
// Two bridges (CLK_DIV 1 and 2) against SPI slave models, checked against
// a byte-level reference of the expected frame, latency and load result.
module tb_spi_memory_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        mr [2];
    logic        mw [2];
    logic [2:0]  opt [2];
    logic [31:0] addr [2];
    logic [31:0] wd [2];
    logic [31:0] resp_stream [2];

    logic [31:0] rd_o [2];
    logic        resp_o [2];
    logic        busy_o [2];
    logic        cs_o [2];
    logic        sck_o [2];
    logic        mosi_o [2];
    logic [0:63] cap [2];
    int          cs_falls [2];

    int passed = 0;
    int total  = 0;
    logic [31:0] rd_model [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            spi_memory_bridge_if bus ();
            logic [0:63] cap_l;
            int          cnt_l   = 0;
            int          falls_l = 0;
            logic        w_miso;

            assign bus.memory_read  = mr[gi];
            assign bus.memory_write = mw[gi];
            assign bus.option       = opt[gi];
            assign bus.address      = addr[gi];
            assign bus.write_data   = wd[gi];
            assign bus.spi_miso     = w_miso;

            assign rd_o[gi]     = bus.read_data;
            assign resp_o[gi]   = bus.memory_response;
            assign busy_o[gi]   = bus.busy;
            assign cs_o[gi]     = bus.spi_cs_n;
            assign sck_o[gi]    = bus.spi_sck;
            assign mosi_o[gi]   = bus.spi_mosi;
            assign cap[gi]      = cap_l;
            assign cs_falls[gi] = falls_l;

            // Slave: data-phase bits come from resp_stream, first byte in [31:24].
            always_comb begin
                w_miso = 1'b0;
                if (cnt_l >= 32 && cnt_l < 64)
                    w_miso = resp_stream[gi][31 - (cnt_l - 32)];
            end

            always @(posedge bus.spi_sck or negedge bus.spi_cs_n) begin
                if (bus.spi_sck) begin
                    if (cnt_l < 64) cap_l[cnt_l] = bus.spi_mosi;
                    cnt_l = cnt_l + 1;
                end else begin
                    cnt_l   = 0;
                    falls_l = falls_l + 1;
                end
            end

            spi_memory_bridge #(.CLK_DIV(gi + 1)) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus.slave)
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One transaction from request to response; inputs are driven at a negedge.
    task automatic run(input int i, input bit rd, input bit wr, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rs,
                       input bit hold);
        int n, nbits, lat, k, falls0;
        logic [63:0] exp_bits, mask, obs_bits;
        logic [31:0] val;
        n      = (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
        nbits  = 32 + 8 * n;
        lat    = 2 + nbits * 2 * (i + 1);
        exp_bits = {(wr ? 8'h02 : 8'h03), a[23:0], 32'h0};
        val = 32'h0;
        for (int b = 0; b < n; b++) begin
            if (wr) exp_bits[31 - 8*b -: 8] = d[8*b +: 8];
            val = val | ({24'h0, rs[31 - 8*b -: 8]} << (8*b));
        end
        if (!o[2] && n == 1) val = {{24{val[7]}}, val[7:0]};
        if (!o[2] && n == 2) val = {{16{val[15]}}, val[15:0]};
        if (!wr) rd_model[i] = val;

        mr[i] = rd; mw[i] = wr; opt[i] = o; addr[i] = a; wd[i] = d; resp_stream[i] = rs;
        falls0 = cs_falls[i];
        @(posedge clk);
        k = 0;
        forever begin
            @(negedge clk);
            if (k == 0) check("busy_after_accept", {63'h0, busy_o[i]}, 64'h1);
            if (resp_o[i] || k > lat + 50) break;
            @(posedge clk);
            k++;
        end
        check("latency", 64'(k), 64'(lat));
        check("read_data", {32'h0, rd_o[i]}, {32'h0, rd_model[i]});
        mask     = ~64'h0 << (64 - nbits);
        obs_bits = cap[i];
        check("mosi_frame", obs_bits & mask, exp_bits & mask);
        check("cs_fall_count", 64'(cs_falls[i]), 64'(falls0 + 1));
        $display("txn inst=%0d rd=%0d wr=%0d opt=%0d addr=%h wd=%h latency=%0d read_data=%h",
                 i, rd, wr, o, a, d, k, rd_o[i]);
        if (hold) begin
            repeat (30) @(negedge clk);
            check("held_no_retrigger", 64'(cs_falls[i]), 64'(falls0 + 1));
            check("held_busy_low", {63'h0, busy_o[i]}, 64'h0);
        end
        mr[i] = 1'b0; mw[i] = 1'b0;
        @(negedge clk);
        check("response_one_cycle", {63'h0, resp_o[i]}, 64'h0);
        @(negedge clk);
        check("busy_released", {63'h0, busy_o[i]}, 64'h0);
        check("read_data_hold", {32'h0, rd_o[i]}, {32'h0, rd_model[i]});
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 2; i++) begin
            mr[i] = 0; mw[i] = 0; opt[i] = 0; addr[i] = 0; wd[i] = 0; resp_stream[i] = 0;
            rd_model[i] = 32'h0;
        end
        #2 rst_n = 1'b0;
        mr[0] = 1'b1; opt[0] = 3'b010; addr[0] = 32'h0000_0010;
        #1;
        check("rst_cs_n", {63'h0, cs_o[0]}, 64'h1);
        check("rst_sck", {63'h0, sck_o[0]}, 64'h0);
        check("rst_mosi", {63'h0, mosi_o[0]}, 64'h0);
        check("rst_resp", {63'h0, resp_o[0]}, 64'h0);
        check("rst_busy", {63'h0, busy_o[0]}, 64'h0);
        check("rst_read_data", {32'h0, rd_o[0]}, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // LW held through reset release, accepted on the first edge
        run(0, 1, 0, 3'b010, 32'h0000_0010, 32'h0, 32'h1122_3344, 0);
        run(0, 1, 0, 3'b000, 32'h0000_0005, 32'h0, 32'h8000_0000, 0);
        run(0, 1, 0, 3'b100, 32'h0000_0005, 32'h0, 32'h8000_0000, 0);
        run(1, 1, 0, 3'b010, 32'h0000_0020, 32'h0, 32'hA1B2_C3D4, 0);
        run(1, 0, 1, 3'b001, 32'h0000_00FE, 32'hABCD_1234, 32'hFFFF_FFFF, 0);
        run(0, 1, 1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1);
        run(0, 1, 0, 3'b010, 32'hFF12_3456, 32'h0, 32'h5566_7788, 0);

        // Reset in the middle of an LW frame
        mr[0] = 1'b1; opt[0] = 3'b010; addr[0] = 32'h0000_0100;
        @(posedge clk);
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        mr[0] = 1'b0;
        rd_model[0] = 32'h0; rd_model[1] = 32'h0;
        #1;
        check("midrst_cs_n", {63'h0, cs_o[0]}, 64'h1);
        check("midrst_sck", {63'h0, sck_o[0]}, 64'h0);
        check("midrst_resp", {63'h0, resp_o[0]}, 64'h0);
        check("midrst_busy", {63'h0, busy_o[0]}, 64'h0);
        check("midrst_read_data", {32'h0, rd_o[0]}, 64'h0);
        check("midrst_read_data_b", {32'h0, rd_o[1]}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (resp_o[0]) seen++;
        end
        check("midrst_no_response", 64'(seen), 64'h0);
        run(0, 1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h0102_0304, 0);

        for (int t = 0; t < 24; t++) begin
            bit r, w;
            r = 1'($urandom_range(0, 1));
            w = r ? 1'($urandom_range(0, 1)) : 1'b1;
            run($urandom_range(0, 1), r, w, 3'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_memory_bridge.md
SPI_MEMORY_BRIDGE -- requirements
Module: spi_memory_bridge

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 1: SCK half-period in clk cycles; legal values 1-255.
REQ-002 SHALL provide parameter READ_CMD, default 8'h03: SPI read opcode.
REQ-003 SHALL provide parameter WRITE_CMD, default 8'h02: SPI write opcode.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 memory_read  in  1  core load request (level).
REQ-007 memory_write  in  1  core store request (level).
REQ-008 option  in  3  RISC-V funct3 size code.
REQ-009 address  in  32  byte address; only [23:0] used.
REQ-010 write_data  in  32  store data, little-endian, LSB first.
REQ-011 read_data  out  32  load result, extended per option.
REQ-012 memory_response  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high from accept through response.
REQ-014 spi_cs_n  out  1  chip select, active low.
REQ-015 spi_sck  out  1  SPI clock, mode 0 (idle low).
REQ-016 spi_mosi  out  1  serial data out, MSB first per byte.
REQ-017 spi_miso  in  1  serial data in.

Function
REQ-018 FSM states SHALL be IDLE, START, XFER, STOP, RELEASE.
REQ-019 IDLE: when memory_read|memory_write sampled high, latch address[23:0], option, write_data; go to START; busy high next cycle.
REQ-020 Both memory_read and memory_write high SHALL be treated as a write.
REQ-021 Byte count n: option[1:0]=00 -> 1, 01 -> 2, 10 -> 4, 11 -> 4.
REQ-022 START: spi_cs_n driven low for one cycle; spi_sck low; first MOSI bit presented.
REQ-023 XFER: shift 32+8n bits: opcode (8), address[23:16], [15:8], [7:0], then n data bytes; byte at lowest address first.
REQ-024 Each bit SHALL span 2*CLK_DIV clk cycles: SCK low for first CLK_DIV, high for second; MOSI changes only while SCK low; MISO sampled on the clk edge where SCK rises.
REQ-025 During write, data bytes SHALL be write_data[7:0], [15:8], ... MSB first; MISO ignored.
REQ-026 During read, MOSI SHALL be 0 in the data phase; received bytes are assembled little-endian.
REQ-027 STOP: spi_cs_n high, spi_sck low, memory_response high exactly one cycle; on reads read_data updated in that same cycle.
REQ-028 Response latency SHALL be exactly 2 + (32+8n)*2*CLK_DIV cycles after the accepting edge.
REQ-029 Read extension: option[2]=0 sign-extends the byte/half, option[2]=1 zero-extends; word loads unchanged; option 011/11x give raw word.
REQ-030 read_data SHALL hold its value across writes and idle periods.
REQ-031 RELEASE: busy low; remain until memory_read and memory_write are both low, then IDLE (no re-trigger on a held request).
REQ-032 Request changes while busy SHALL be ignored; latched values govern the transaction.
REQ-033 spi_sck SHALL be low whenever spi_cs_n is high.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, memory_response=0, busy=0, read_data=0, regardless of transaction in progress.
REQ-035 After rst_n release, a request held high SHALL be accepted on the first rising edge.

Verification
REQ-036 LW at 0x000010, CLK_DIV=1, slave model returns bytes 11,22,33,44 -> MOSI 03 00 00 10; read_data=0x44332211; response at cycle 130.
REQ-037 LB at 0x000005, slave returns 0x80 -> read_data=0xFFFFFF80, response at cycle 82; repeat as LBU -> 0x00000080.
REQ-038 SH at 0x0000FE, write_data=0xABCD1234, CLK_DIV=2 -> MOSI 02 00 00 FE 34 12; response at cycle 2+48*4=194; read_data unchanged.
REQ-039 Both memory_read and memory_write high, request held after response -> single write transaction; no second cs_n fall until requests drop and reassert.
REQ-040 rst_n asserted mid-XFER of LW -> spi_cs_n high, spi_sck low, no response; new LW after reset completes normally.
REQ-041 address=0xFF123456 -> transmitted address bytes 12 34 56 (upper byte ignored).
